cacheline_burst_adaptor: RTL and testbench
==========================================

Name: cacheline_burst_adaptor

Overview:
- Sits directly downstream of the cache datapath core and converts its full-line requests into bursts for physical memory.
- Line side: one 256-bit line read or write per request, with a single-cycle response.
- Memory side: a 4-beat burst of 64-bit words, one beat per memory response cycle.
- Serves the last cache level; every line fill and every writeback passes through this block.

Parameters:
- s_line, 256, cache line width in bits.
- s_burst, 64, memory beat width in bits; s_line must be an integer multiple of s_burst.
- num_beats, s_line/s_burst (4), beats per line transfer.
- s_offset, 5, line offset bits cleared in the outgoing address.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- line_read_i  input  1  cache requests a line fill; held until line_resp_o.
- line_write_i  input  1  cache requests a line writeback; held until line_resp_o.
- line_address_i  input  32  line request address.
- line_wdata_i  input  s_line  writeback data.
- line_rdata_o  output  s_line  assembled fill data.
- line_resp_o  output  1  one-cycle completion pulse.
- mem_read_o  output  1  burst read request to memory.
- mem_write_o  output  1  burst write request to memory.
- mem_address_o  output  32  line-aligned burst address.
- mem_wdata_o  output  s_burst  current write beat.
- mem_rdata_i  input  s_burst  read beat; valid when mem_resp_i=1.
- mem_resp_i  input  1  memory beat handshake; high for each of the num_beats beats.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE, beat counter 0, address and line buffers 0.
- States: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE:
  - On line_read_i=1, latch line_address_i and go to RD_BURST.
  - Otherwise, on line_write_i=1, latch line_address_i and line_wdata_i and go to WR_BURST.
  - If both requests are high, read wins; this case is illegal from the controller and a bench assertion flags it.
  - mem_resp_i is ignored in IDLE.
- Address:
  - mem_address_o = {latched_address[31:s_offset], s_offset'b0}.
  - Valid whenever mem_read_o or mem_write_o is high.
  - Buffers are registered, so a change on line_address_i mid-burst has no effect.
- RD_BURST:
  - mem_read_o=1 for the whole state.
  - Each cycle with mem_resp_i=1 writes mem_rdata_i into line_rdata_o[count*s_burst +: s_burst], then increments count.
  - Beat 0 lands in bits [63:0].
  - Cycles without mem_resp_i stall with no state change; gaps between beats are legal.
  - On the beat where count=num_beats-1: count wraps to 0, state goes to DONE, and mem_read_o drops to 0 on the next cycle.
- WR_BURST:
  - mem_write_o=1 for the whole state.
  - mem_wdata_o = latched_line[count*s_burst +: s_burst], combinational from count, so beat 0 is presented in the first WR_BURST cycle.
  - count advances on each mem_resp_i.
  - After the last beat, state goes to DONE and mem_write_o drops.
- DONE:
  - line_resp_o=1 for exactly one cycle, then unconditionally back to IDLE.
  - line_rdata_o is complete and stable in the line_resp_o cycle and holds until the next read burst begins writing beats.
  - line_read_i/line_write_i are not sampled in DONE. This gives the controller one cycle to deassert and prevents double acceptance.
- Latency: best case, with mem_resp_i on consecutive cycles starting the first cycle after the request:
  - request cycle T (IDLE accepts);
  - beats at T+1..T+4;
  - line_resp_o at T+5.
- Write completion: line_resp_o is never asserted before the fourth mem_resp_i of a write.
- Extra mem_resp_i in DONE/IDLE: ignored; no buffer update.
- Reset mid-burst:
  - The next edge forces IDLE, count=0, and mem_read_o/mem_write_o/line_resp_o to 0.
  - line_rdata_o clears to 0.
  - No partial response is ever issued.
- Counter is $clog2(num_beats) bits and wraps naturally at num_beats when num_beats is a power of two.

Test Plan:
- Read, back-to-back beats:
  - Stimulus: line_read_i with address 0x0000_1234; memory returns 0x11..11, 0x22..22, 0x33..33, 0x44..44 on 4 consecutive resp cycles.
  - Required: mem_address_o=0x0000_1220; line_resp_o at T+5; line_rdata_o = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Write:
  - Stimulus: line_write_i with line_wdata_i = 256'h DDDD..CCCC..BBBB..AAAA (64-bit lanes).
  - Required: mem_wdata_o sequence AAAA.., BBBB.., CCCC.., DDDD.. on the four resp cycles; mem_write_o low and line_resp_o high the cycle after the fourth.
- Stalled read:
  - Stimulus: resp beats separated by 0, 3, 1 idle cycles.
  - Required: correct assembly; line_resp_o exactly once, only after beat 4; mem_read_o held throughout.
- Held request across DONE:
  - Stimulus: controller keeps line_read_i high through the line_resp_o cycle, then deasserts.
  - Required: no second mem_read_o.
  - Stimulus: a new line_write_i the cycle after.
  - Required: accepted from IDLE.
- Reset mid-read:
  - Stimulus: rst after beat 2.
  - Required: all outputs 0 next cycle, no line_resp_o. A following read completes with count starting at 0.
- Spurious mem_resp_i in IDLE:
  - Stimulus: mem_resp_i pulses in IDLE.
  - Required: no state change and line_rdata_o unchanged.

Source files
------------

// File: rtl/cacheline_burst_adaptor_if.sv
// Line-side and memory-side signals of the cache line burst adaptor.
// Signal suffixes are from the adaptor's point of view.
// The adaptor connects through the slave modport.
// The cache controller and memory model connect through the master modport.
interface cacheline_burst_adaptor_if #(
  parameter int s_line  = 256,
  parameter int s_burst = 64
) ();
  logic                line_read_i;
  logic                line_write_i;
  logic [31:0]         line_address_i;
  logic [s_line-1:0]   line_wdata_i;
  logic [s_line-1:0]   line_rdata_o;
  logic                line_resp_o;
  logic                mem_read_o;
  logic                mem_write_o;
  logic [31:0]         mem_address_o;
  logic [s_burst-1:0]  mem_wdata_o;
  logic [s_burst-1:0]  mem_rdata_i;
  logic                mem_resp_i;

  modport slave (
    input  line_read_i, line_write_i, line_address_i, line_wdata_i,
    input  mem_rdata_i, mem_resp_i,
    output line_rdata_o, line_resp_o,
    output mem_read_o, mem_write_o, mem_address_o, mem_wdata_o
  );

  modport master (
    output line_read_i, line_write_i, line_address_i, line_wdata_i,
    output mem_rdata_i, mem_resp_i,
    input  line_rdata_o, line_resp_o,
    input  mem_read_o, mem_write_o, mem_address_o, mem_wdata_o
  );
endinterface

// File: rtl/cacheline_burst_adaptor.sv
// Converts single full-line cache requests into num_beats-beat memory bursts.
// Fill data is assembled one beat-wide lane at a time.
// Writeback data is latched whole and then presented one beat per count.

// One beat-wide slice of the fill buffer.
// Captures the memory beat when its lane is selected.
module cacheline_burst_lane #(
  parameter int w = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we_i,
  input  logic [w-1:0] d_i,
  output logic [w-1:0] q_o
);
  logic [w-1:0] q_q;

  // Lane register: cleared on reset, loaded on its beat.
  always_ff @(posedge clk) begin
    if (rst)       q_q <= '0;
    else if (we_i) q_q <= d_i;
  end

  assign q_o = q_q;
endmodule

module cacheline_burst_adaptor #(
  parameter int s_line   = 256,
  parameter int s_burst  = 64,
  parameter int s_offset = 5
) (
  input logic clk,
  input logic rst,
  cacheline_burst_adaptor_if.slave bus
);
  localparam int num_beats = s_line / s_burst;
  localparam int cw        = (num_beats > 1) ? $clog2(num_beats) : 1;
  localparam logic [cw-1:0] last_beat = cw'(num_beats - 1);

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_e;

  state_e                             state_q, state_d;
  logic [cw-1:0]                      count_q, count_d;
  // Only the line-aligned part of the address is ever used.
  logic [31-s_offset:0]               addr_q, addr_d;
  logic [num_beats-1:0][s_burst-1:0]  wline_q, wline_d;
  logic [num_beats-1:0][s_burst-1:0]  rline;
  logic [num_beats-1:0]               beat_we;

  // State, beat counter, latched address and writeback line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      addr_q  <= '0;
      wline_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
    end
  end

  // Next state, request capture and per-beat fill lane select.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    beat_we = '0;
    unique case (state_q)
      IDLE: begin
        // A read wins if both requests are high. The controller must never do that.
        if (bus.line_read_i) begin
          addr_d  = bus.line_address_i[31:s_offset];
          state_d = RD_BURST;
        end else if (bus.line_write_i) begin
          addr_d  = bus.line_address_i[31:s_offset];
          wline_d = bus.line_wdata_i;
          state_d = WR_BURST;
        end
      end
      RD_BURST: begin
        if (bus.mem_resp_i) begin
          beat_we[count_q] = 1'b1;
          if (count_q == last_beat) begin
            count_d = '0;
            state_d = DONE;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      WR_BURST: begin
        if (bus.mem_resp_i) begin
          if (count_q == last_beat) begin
            count_d = '0;
            state_d = DONE;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      // Requests are not sampled here.
      // This gives the controller a cycle to drop its request after the response.
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Fill buffer, one lane per beat position.
  for (genvar g = 0; g < num_beats; g++) begin : g_lane
    cacheline_burst_lane #(.w(s_burst)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .we_i (beat_we[g]),
      .d_i  (bus.mem_rdata_i),
      .q_o  (rline[g])
    );
  end

  assign bus.line_rdata_o  = rline;
  assign bus.line_resp_o   = (state_q == DONE);
  assign bus.mem_read_o    = (state_q == RD_BURST);
  assign bus.mem_write_o   = (state_q == WR_BURST);
  assign bus.mem_address_o = {addr_q, {s_offset{1'b0}}};
  assign bus.mem_wdata_o   = wline_q[count_q];
endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Self-checking bench for cacheline_burst_adaptor.
// It runs a table of cycle vectors, hand-written corner-case sequences and
// random transactions checked against a transaction-level model.
module tb_cacheline_burst_adaptor;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cacheline_burst_adaptor_if #(.s_line(256), .s_burst(64)) bus ();

  cacheline_burst_adaptor #(.s_line(256), .s_burst(64), .s_offset(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // The controller must never raise both requests at once.
  always @(posedge clk)
    if (!rst) assert (!(bus.line_read_i && bus.line_write_i))
      else $error("illegal: read and write requested together");

  task automatic chk_b(input string n, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  task automatic chk_a(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  task automatic chk_w(input string n, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  task automatic chk_l(input string n, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctl(input string n, input logic r, input logic w, input logic l);
    chk_b({n, " mem_read"}, bus.mem_read_o, r);
    chk_b({n, " mem_write"}, bus.mem_write_o, w);
    chk_b({n, " line_resp"}, bus.line_resp_o, l);
  endtask

  typedef struct {
    logic        rd, wr, rsp;
    logic [31:0] addr;
    logic [63:0] beat;
    logic        e_mrd, e_mwr, e_lrsp;
    logic [31:0] e_addr;
    logic [63:0] e_wd;
    logic        ck_line;
  } vec_t;

  function automatic vec_t mk(input logic rd, input logic wr, input logic rsp,
                              input logic [31:0] addr, input logic [63:0] beat,
                              input logic mrd, input logic mwr, input logic lrsp,
                              input logic [31:0] eaddr, input logic [63:0] ewd,
                              input logic ckl);
    vec_t v;
    v.rd = rd; v.wr = wr; v.rsp = rsp; v.addr = addr; v.beat = beat;
    v.e_mrd = mrd; v.e_mwr = mwr; v.e_lrsp = lrsp;
    v.e_addr = eaddr; v.e_wd = ewd; v.ck_line = ckl;
    return v;
  endfunction

  vec_t tbl[12];
  logic [63:0]  b1, b2, b3, b4, wa, wb, wc, wd, junk;
  logic [255:0] w_line, r_line, last_line;

  initial begin
    b1 = 64'h1111_1111_1111_1111; b2 = 64'h2222_2222_2222_2222;
    b3 = 64'h3333_3333_3333_3333; b4 = 64'h4444_4444_4444_4444;
    wa = 64'hAAAA_AAAA_AAAA_AAAA; wb = 64'hBBBB_BBBB_BBBB_BBBB;
    wc = 64'hCCCC_CCCC_CCCC_CCCC; wd = 64'hDDDD_DDDD_DDDD_DDDD;
    junk = 64'hDEAD_BEEF_0BAD_F00D;
    w_line = {wd, wc, wb, wa};
    r_line = {b4, b3, b2, b1};

    // Back-to-back read, request held through the response cycle.
    // Then a write accepted straight from IDLE. Address and data change mid-burst.
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 32'h0000_1234, 64'h0, 1'b1, 1'b0, 1'b0, 32'h0000_1220, 64'h0, 1'b0);
    tbl[1]  = mk(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, b1,    1'b1, 1'b0, 1'b0, 32'h0000_1220, 64'h0, 1'b0);
    tbl[2]  = mk(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, b2,    1'b1, 1'b0, 1'b0, 32'h0000_1220, 64'h0, 1'b0);
    tbl[3]  = mk(1'b1, 1'b0, 1'b1, 32'hABCD_EF00, b3,    1'b1, 1'b0, 1'b0, 32'h0000_1220, 64'h0, 1'b0);
    tbl[4]  = mk(1'b1, 1'b0, 1'b1, 32'hABCD_EF00, b4,    1'b0, 1'b0, 1'b1, 32'h0,         64'h0, 1'b1);
    tbl[5]  = mk(1'b1, 1'b0, 1'b1, 32'h0,         junk,  1'b0, 1'b0, 1'b0, 32'h0,         64'h0, 1'b1);
    tbl[6]  = mk(1'b0, 1'b1, 1'b0, 32'h0000_5678, 64'h0, 1'b0, 1'b1, 1'b0, 32'h0000_5660, wa,    1'b1);
    tbl[7]  = mk(1'b0, 1'b1, 1'b1, 32'hFFFF_FFE0, junk,  1'b0, 1'b1, 1'b0, 32'h0000_5660, wb,    1'b1);
    tbl[8]  = mk(1'b0, 1'b1, 1'b1, 32'hFFFF_FFE0, junk,  1'b0, 1'b1, 1'b0, 32'h0000_5660, wc,    1'b1);
    tbl[9]  = mk(1'b0, 1'b1, 1'b1, 32'hFFFF_FFE0, junk,  1'b0, 1'b1, 1'b0, 32'h0000_5660, wd,    1'b1);
    tbl[10] = mk(1'b0, 1'b1, 1'b1, 32'hFFFF_FFE0, junk,  1'b0, 1'b0, 1'b1, 32'h0,         64'h0, 1'b1);
    tbl[11] = mk(1'b0, 1'b0, 1'b0, 32'h0,         64'h0, 1'b0, 1'b0, 1'b0, 32'h0,         64'h0, 1'b1);

    rst = 1'b1;
    bus.line_read_i = 1'b0; bus.line_write_i = 1'b0;
    bus.line_address_i = '0; bus.line_wdata_i = '0;
    bus.mem_rdata_i = '0; bus.mem_resp_i = 1'b0;

    // Reset state.
    tick(); tick();
    chk_ctl("reset", 1'b0, 1'b0, 1'b0);
    chk_a("reset mem_address", bus.mem_address_o, 32'h0);
    chk_w("reset mem_wdata", bus.mem_wdata_o, 64'h0);
    chk_l("reset line_rdata", bus.line_rdata_o, 256'h0);
    rst = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < 12; i++) begin
      bus.line_read_i    = tbl[i].rd;
      bus.line_write_i   = tbl[i].wr;
      bus.line_address_i = tbl[i].addr;
      bus.mem_resp_i     = tbl[i].rsp;
      bus.mem_rdata_i    = tbl[i].beat;
      bus.line_wdata_i   = (i >= 7) ? {8{$urandom}} : w_line;
      tick();
      chk_ctl($sformatf("tbl[%0d]", i), tbl[i].e_mrd, tbl[i].e_mwr, tbl[i].e_lrsp);
      if (tbl[i].e_mrd || tbl[i].e_mwr)
        chk_a($sformatf("tbl[%0d] mem_address", i), bus.mem_address_o, tbl[i].e_addr);
      if (tbl[i].e_mwr)
        chk_w($sformatf("tbl[%0d] mem_wdata", i), bus.mem_wdata_o, tbl[i].e_wd);
      if (tbl[i].ck_line)
        chk_l($sformatf("tbl[%0d] line_rdata", i), bus.line_rdata_o, r_line);
    end

    // Stalled read: beats at cycles 0,1,5,7 leave gaps of 0, 3 and 1 cycles.
    begin
      logic [63:0] bt[4];
      int k;
      bool_resp_pattern: begin end
      for (int j = 0; j < 4; j++) bt[j] = {$urandom, $urandom};
      bus.line_read_i = 1'b1; bus.line_address_i = 32'h8000_0047;
      bus.mem_resp_i = 1'b0;
      tick();
      chk_ctl("stall accept", 1'b1, 1'b0, 1'b0);
      k = 0;
      for (int c = 0; c < 8; c++) begin
        bus.mem_resp_i = (c == 0 || c == 1 || c == 5 || c == 7);
        bus.mem_rdata_i = bus.mem_resp_i ? bt[k] : {$urandom, $urandom};
        if (bus.mem_resp_i) k++;
        tick();
        chk_ctl($sformatf("stall c%0d", c), (c < 7), 1'b0, (c == 7));
        if (c < 7) chk_a($sformatf("stall c%0d mem_address", c), bus.mem_address_o, 32'h8000_0040);
      end
      last_line = {bt[3], bt[2], bt[1], bt[0]};
      chk_l("stall line_rdata", bus.line_rdata_o, last_line);
      bus.mem_resp_i = 1'b0; bus.line_read_i = 1'b0;
      tick();
      chk_ctl("stall after", 1'b0, 1'b0, 1'b0);
    end

    // Reset after two read beats, then a clean read.
    begin
      logic [63:0] bt[4];
      for (int j = 0; j < 4; j++) bt[j] = {$urandom, $urandom};
      bus.line_read_i = 1'b1; bus.line_address_i = 32'h0000_0100;
      tick();
      for (int j = 0; j < 2; j++) begin
        bus.mem_resp_i = 1'b1; bus.mem_rdata_i = {$urandom, $urandom};
        tick();
      end
      rst = 1'b1; bus.mem_resp_i = 1'b0; bus.line_read_i = 1'b0;
      tick();
      chk_ctl("rst mid-read", 1'b0, 1'b0, 1'b0);
      chk_l("rst mid-read line_rdata", bus.line_rdata_o, 256'h0);
      chk_a("rst mid-read mem_address", bus.mem_address_o, 32'h0);
      rst = 1'b0;
      tick();
      chk_ctl("rst after", 1'b0, 1'b0, 1'b0);
      bus.line_read_i = 1'b1; bus.line_address_i = 32'h0000_0200;
      tick();
      for (int j = 0; j < 4; j++) begin
        bus.mem_resp_i = 1'b1; bus.mem_rdata_i = bt[j];
        tick();
      end
      bus.mem_resp_i = 1'b0; bus.line_read_i = 1'b0;
      chk_ctl("post-rst read", 1'b0, 1'b0, 1'b1);
      last_line = {bt[3], bt[2], bt[1], bt[0]};
      chk_l("post-rst line_rdata", bus.line_rdata_o, last_line);
      tick();
    end

    // Spurious memory responses in IDLE.
    for (int j = 0; j < 3; j++) begin
      bus.mem_resp_i = 1'b1; bus.mem_rdata_i = {$urandom, $urandom};
      tick();
      chk_ctl($sformatf("spurious %0d", j), 1'b0, 1'b0, 1'b0);
      chk_l($sformatf("spurious %0d line_rdata", j), bus.line_rdata_o, last_line);
    end
    bus.mem_resp_i = 1'b0;

    // Random transactions against a transaction-level model.
    for (int t = 0; t < 40; t++) begin
      logic         is_rd;
      logic [31:0]  a;
      logic [255:0] wl;
      logic [63:0]  bt[4];
      is_rd = 1'($urandom_range(0, 1));
      a = $urandom;
      wl = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      for (int j = 0; j < 4; j++) bt[j] = {$urandom, $urandom};
      bus.line_read_i = is_rd; bus.line_write_i = !is_rd;
      bus.line_address_i = a; bus.line_wdata_i = wl; bus.mem_resp_i = 1'b0;
      tick();
      for (int k = 0; k < 4; k++) begin
        int gap;
        gap = $urandom_range(0, 2);
        for (int c = 0; c <= gap; c++) begin
          bus.line_address_i = $urandom;
          bus.line_wdata_i = {8{$urandom}};
          chk_ctl($sformatf("rnd%0d b%0d", t, k), is_rd, !is_rd, 1'b0);
          chk_a($sformatf("rnd%0d b%0d mem_address", t, k), bus.mem_address_o, a & ~32'h1F);
          if (!is_rd) chk_w($sformatf("rnd%0d b%0d mem_wdata", t, k), bus.mem_wdata_o, wl[64*k +: 64]);
          bus.mem_resp_i = (c == gap);
          bus.mem_rdata_i = (c == gap) ? bt[k] : {$urandom, $urandom};
          tick();
        end
      end
      bus.mem_resp_i = 1'b0;
      if (is_rd) last_line = {bt[3], bt[2], bt[1], bt[0]};
      chk_ctl($sformatf("rnd%0d done", t), 1'b0, 1'b0, 1'b1);
      chk_l($sformatf("rnd%0d line_rdata", t), bus.line_rdata_o, last_line);
      if ($urandom_range(0, 1) == 0) begin
        bus.line_read_i = 1'b0; bus.line_write_i = 1'b0;
      end
      tick();
      bus.line_read_i = 1'b0; bus.line_write_i = 1'b0;
      chk_ctl($sformatf("rnd%0d idle", t), 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < int'($urandom_range(0, 2)); c++) begin
        bus.mem_resp_i = 1'($urandom_range(0, 1)); bus.mem_rdata_i = {$urandom, $urandom};
        tick();
        chk_ctl($sformatf("rnd%0d gap%0d", t, c), 1'b0, 1'b0, 1'b0);
        chk_l($sformatf("rnd%0d gap%0d line_rdata", t, c), bus.line_rdata_o, last_line);
      end
      bus.mem_resp_i = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
